// File: rtl/pll_reset_sequencer.sv
// Turns the asynchronous PLL `locked` flag into a qualified, glitch-free active-high
// core reset in the clkin domain, and counts lock losses observed while running.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       locked,
  input  logic       soft_reset,
  output logic       reset_out,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lock_lost_count
);

  localparam longint CNT_LIMIT = longint'(1) << CNT_W;

  generate
    if (SYNC_STAGES < 2 || LOCK_CYCLES < 1 || HOLD_CYCLES < 1 ||
        longint'(LOCK_CYCLES) >= CNT_LIMIT || longint'(HOLD_CYCLES) >= CNT_LIMIT) begin : gBadParams
      $error("pll_reset_sequencer: illegal parameter combination");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seqState_t;

  logic [SYNC_STAGES-1:0] syncFf;
  logic                   lockedS;
  seqState_t              curState, nextState;
  logic [CNT_W-1:0]       cnt, cntNext;
  logic [7:0]             lostCnt, lostCntNext;

  // Synchroniser: only the last stage is allowed to reach the FSM
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      syncFf <= '0;
    end else begin
      syncFf <= {syncFf[SYNC_STAGES-2:0], locked};
    end
  end

  assign lockedS = syncFf[SYNC_STAGES-1];

  always_comb begin
    nextState   = curState;
    cntNext     = cnt;
    lostCntNext = lostCnt;
    case (curState)
      WAIT_LOCK: begin
        if (lockedS) begin
          nextState = STABLE;
          cntNext   = '0;
        end
      end
      STABLE: begin
        if (!lockedS) begin
          nextState = WAIT_LOCK;
          cntNext   = '0;
        end else if (cnt == LOCK_LAST) begin
          nextState = HOLD;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_ONE;
        end
      end
      HOLD: begin
        if (!lockedS) begin
          nextState = WAIT_LOCK;
          cntNext   = '0;
        end else if (cnt == HOLD_LAST) begin
          nextState = RUN;
        end else begin
          cntNext = cnt + CNT_ONE;
        end
      end
      RUN: begin
        // Lock loss wins over a simultaneous soft reset request
        if (!lockedS) begin
          nextState = WAIT_LOCK;
          cntNext   = '0;
          if (lostCnt != 8'hFF) begin
            lostCntNext = lostCnt + 8'd1;
          end
        end else if (soft_reset) begin
          nextState = HOLD;
          cntNext   = '0;
        end
      end
      default: begin
        nextState = WAIT_LOCK;
        cntNext   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch on the same edge as state
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      curState  <= WAIT_LOCK;
      cnt       <= '0;
      lostCnt   <= '0;
      reset_out <= 1'b1;
      ready     <= 1'b0;
    end else begin
      curState  <= nextState;
      cnt       <= cntNext;
      lostCnt   <= lostCntNext;
      reset_out <= (nextState != RUN);
      ready     <= (nextState == RUN);
    end
  end

  assign state           = curState;
  assign lock_lost_count = lostCnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a timestamp-based reference model predicts
// the outputs after every clkin edge; a negedge monitor pops and compares them.
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int LOCK = 8;
  localparam int HOLD = 4;

  logic       clkin = 1'b0;
  logic       resetn;
  logic       locked;
  logic       soft_reset;
  logic       reset_out;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_lost_count;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC),
    .LOCK_CYCLES(LOCK),
    .HOLD_CYCLES(HOLD),
    .CNT_W(16)
  ) dut (
    .clkin(clkin),
    .resetn(resetn),
    .locked(locked),
    .soft_reset(soft_reset),
    .reset_out(reset_out),
    .ready(ready),
    .state(state),
    .lock_lost_count(lock_lost_count)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [1:0] st;
    logic       ro;
    logic       rdy;
    logic [7:0] cnt;
    int         edgeNo;
  } expect_t;

  expect_t expQ[$];
  int compared   = 0;
  int mismatched = 0;

  // Reference model: qualification is tracked as the edge number at which the
  // sequencer entered STABLE; state follows from the age since that edge.
  int         edgeNum  = 0;
  bit         qual     = 0;
  int         qualStart = 0;
  int         lostModel = 0;
  logic [1:0] prevState = 2'd0;
  bit         sh[SYNC];

  function automatic logic [1:0] stateFromAge(int age);
    if (age < LOCK) return 2'd1;
    else if (age < LOCK + HOLD) return 2'd2;
    else return 2'd3;
  endfunction

  task automatic modelClear();
    qual      = 0;
    lostModel = 0;
    prevState = 2'd0;
    for (int i = 0; i < SYNC; i++) sh[i] = 1'b0;
  endtask

  task automatic pushExpect();
    expect_t e;
    e.st     = prevState;
    e.ro     = (prevState != 2'd3);
    e.rdy    = (prevState == 2'd3);
    e.cnt    = 8'(lostModel);
    e.edgeNo = edgeNum;
    expQ.push_back(e);
  endtask

  task automatic modelEdge(input bit lk, input bit sr, input bit rn);
    bit ls;
    edgeNum++;
    if (!rn) begin
      modelClear();
    end else begin
      ls = sh[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = lk;
      if (!qual) begin
        if (ls) begin
          qual      = 1;
          qualStart = edgeNum;
        end
      end else if (!ls) begin
        qual = 0;
        if (prevState == 2'd3 && lostModel < 255) lostModel++;
      end else if (prevState == 2'd3 && sr) begin
        qualStart = edgeNum - LOCK;
      end
      prevState = qual ? stateFromAge(edgeNum - qualStart) : 2'd0;
    end
    pushExpect();
  endtask

  // Drive inputs for the coming edge, then predict the outputs after it
  task automatic drive(input bit lk, input bit sr, input bit rn);
    locked     = lk;
    soft_reset = sr;
    resetn     = rn;
    @(posedge clkin);
    modelEdge(lk, sr, rn);
    #1;
  endtask

  // Pull resetn low between edges; outputs must clear before the next edge
  task automatic asyncReset(input bit lk);
    @(posedge clkin);
    edgeNum++;
    modelClear();
    pushExpect();
    #2;
    resetn     = 1'b0;
    locked     = lk;
    soft_reset = 1'b0;
    drive(lk, 0, 0);
    drive(lk, 0, 0);
  endtask

  always @(negedge clkin) begin
    if (expQ.size() > 0) begin
      expect_t e;
      e = expQ.pop_front();
      compared++;
      if (state !== e.st || reset_out !== e.ro || ready !== e.rdy || lock_lost_count !== e.cnt) begin
        mismatched++;
        $display("FAIL outputs@edge%0d: got state=%0d reset_out=%0b ready=%0b count=%0d, want state=%0d reset_out=%0b ready=%0b count=%0d",
                 e.edgeNo, state, reset_out, ready, lock_lost_count, e.st, e.ro, e.rdy, e.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn     = 1'b0;
    locked     = 1'b0;
    soft_reset = 1'b0;
    modelClear();

    repeat (3) drive(0, 0, 0);
    repeat (3) drive(0, 0, 1);

    // First lock: 0 -> 1 -> 2 -> 3
    repeat (20) drive(1, 0, 1);

    // Short lock then drop: qualification restarts
    repeat (5) drive(0, 0, 1);
    repeat (5) drive(1, 0, 1);
    repeat (3) drive(0, 0, 1);
    repeat (20) drive(1, 0, 1);

    // Lock loss from RUN and relock
    repeat (5) drive(0, 0, 1);
    repeat (20) drive(1, 0, 1);

    // Soft reset in RUN
    drive(1, 1, 1);
    repeat (8) drive(1, 0, 1);

    // Soft reset on the same edge the synchronised lock falls
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(0, 1, 1);
    repeat (2) drive(0, 0, 1);
    repeat (20) drive(1, 0, 1);

    // Asynchronous reset during HOLD, then during RUN with a non-zero count
    drive(1, 1, 1);
    drive(1, 0, 1);
    asyncReset(1);
    repeat (20) drive(1, 0, 1);
    repeat (5) drive(0, 0, 1);
    repeat (20) drive(1, 0, 1);
    asyncReset(1);
    repeat (20) drive(1, 0, 1);

    // Saturation of the lock-loss counter
    repeat (300) begin
      repeat (16) drive(1, 0, 1);
      repeat (3) drive(0, 0, 1);
    end
    repeat (20) drive(1, 0, 1);

    // Randomised lock runs, glitches, soft resets and occasional async resets
    repeat (250) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 30);
      lo = $urandom_range(1, 5);
      for (int i = 0; i < hi; i++) drive(1, ($urandom_range(0, 7) == 0), 1);
      for (int i = 0; i < lo; i++) drive(0, ($urandom_range(0, 3) == 0), 1);
      if ($urandom_range(0, 29) == 0) asyncReset($urandom_range(0, 1) == 1);
    end

    drive(0, 0, 1);
    @(negedge clkin);
    @(negedge clkin);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
